// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep response stagger: FSM states, OBI response
// and the per-hart beat that travels down each delay line.
package lockstep_pkg;

    localparam int OBI_DW = 32;
    localparam int IRQ_W  = 32;

    typedef enum logic [1:0] {
        BYPASS = 2'b00,
        ACTIVE = 2'b01,
        DRAIN  = 2'b10
    } stagger_state_e;

    typedef struct packed {
        logic              gnt;
        logic              rvalid;
        logic [OBI_DW-1:0] rdata;
    } obi_resp_t;

    // Everything a follower sees late; gnt is deliberately absent.
    typedef struct packed {
        logic              instr_rvalid;
        logic [OBI_DW-1:0] instr_rdata;
        logic              data_rvalid;
        logic [OBI_DW-1:0] data_rdata;
        logic [IRQ_W-1:0]  intr;
        logic              debug;
    } stagger_beat_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lockstep_tap_delay.sv
// Fixed-depth shift line of stagger beats with a runtime output tap.
// Entry 0 holds the beat captured on the previous shifting cycle.
module lockstep_tap_delay
    import lockstep_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAP_W = idx_w(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_shift,
    input  logic              i_zero,
    input  stagger_beat_t     i_beat,
    input  logic [TAP_W-1:0]  i_tap,
    output stagger_beat_t     o_beat
);

    stagger_beat_t [DEPTH-1:0] r_line;

    // Shift in the new beat (or a bubble while draining); clear wins over shift.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_line <= '0;
        end else if (i_clr) begin
            r_line <= '0;
        end else if (i_shift) begin
            if (i_zero) r_line[0] <= '0;
            else        r_line[0] <= i_beat;
            for (int k = 1; k < DEPTH; k++) r_line[k] <= r_line[k-1];
        end
    end

    // Tap select; indices past the end read as an empty beat.
    always_comb begin
        o_beat = '0;
        if (32'(i_tap) < DEPTH) o_beat = r_line[i_tap];
    end

endmodule

// File: rtl/lockstep_resp_stagger.sv
// Response-side stagger for a lockstep cluster: the latched leader hart sees
// responses, interrupts and debug undelayed, followers see them D_l cycles late.
// gnt always bypasses. Disabling drains the lines so no delayed beat is lost.
module lockstep_resp_stagger
    import lockstep_pkg::*;
#(
    parameter int NHARTS    = 3,
    parameter int MAX_DELAY = 4,
    parameter int DW        = 32,
    parameter int NIRQ      = 32,
    localparam int DLY_W    = $clog2(MAX_DELAY+1),
    localparam int LEAD_W   = $clog2(NHARTS)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic [DLY_W-1:0]             delay_i,
    input  logic [LEAD_W-1:0]            leader_i,
    input  obi_resp_t [NHARTS-1:0]       instr_resp_i,
    output obi_resp_t [NHARTS-1:0]       instr_resp_o,
    input  obi_resp_t [NHARTS-1:0]       data_resp_i,
    output obi_resp_t [NHARTS-1:0]       data_resp_o,
    input  logic [NHARTS-1:0][NIRQ-1:0]  intr_i,
    output logic [NHARTS-1:0][NIRQ-1:0]  intr_o,
    input  logic [NHARTS-1:0]            debug_i,
    output logic [NHARTS-1:0]            debug_o,
    output logic                         busy_o,
    output logic [1:0]                   state_o,
    output logic                         drain_err_o
);

    localparam int TAP_W = idx_w(MAX_DELAY);

    stagger_state_e            r_state, w_state_nxt;
    logic [DLY_W-1:0]          r_dly, r_cnt, w_dly_sat;
    logic [LEAD_W-1:0]         r_lead, w_lead_sel;
    logic                      r_err;
    logic                      w_arm, w_busy, w_drain, w_follow_rv;
    logic [TAP_W-1:0]          w_tap_idx;
    stagger_beat_t [NHARTS-1:0] w_beat_in, w_beat_dly;

    assign w_dly_sat  = (32'(delay_i) > MAX_DELAY) ? DLY_W'(MAX_DELAY) : delay_i;
    assign w_lead_sel = (32'(leader_i) >= NHARTS) ? '0 : leader_i;
    assign w_arm      = (r_state == BYPASS) && enable_i && (w_dly_sat != '0);
    assign w_busy     = (r_state == ACTIVE) || (r_state == DRAIN);
    assign w_drain    = (r_state == DRAIN);
    // Tap D_l-1 yields exactly D_l cycles of latency.
    assign w_tap_idx  = (r_dly == '0) ? '0 : TAP_W'(r_dly - DLY_W'(1));

    // Any follower beat arriving now; during DRAIN it would be lost.
    always_comb begin
        w_follow_rv = 1'b0;
        for (int h = 0; h < NHARTS; h++) begin
            if (LEAD_W'(h) != r_lead && (instr_resp_i[h].rvalid || data_resp_i[h].rvalid))
                w_follow_rv = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= BYPASS;
        else         r_state <= w_state_nxt;
    end

    // Next state; the illegal encoding falls back to BYPASS.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BYPASS:  if (w_arm) w_state_nxt = ACTIVE;
            ACTIVE:  if (!enable_i) w_state_nxt = DRAIN;
            DRAIN:   if (r_cnt <= DLY_W'(1)) w_state_nxt = BYPASS;
            default: w_state_nxt = BYPASS;
        endcase
    end

    // Latched config, drain countdown and sticky drain error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dly  <= '0;
            r_lead <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_arm) begin
                r_dly  <= w_dly_sat;
                r_lead <= w_lead_sel;
                r_err  <= 1'b0;
            end else if (w_drain && w_follow_rv) begin
                r_err  <= 1'b1;
            end
            if (r_state == ACTIVE && !enable_i) r_cnt <= r_dly;
            else if (w_drain && r_cnt != '0)    r_cnt <= r_cnt - DLY_W'(1);
        end
    end

    for (genvar g = 0; g < NHARTS; g++) begin : g_hart
        logic [DW-1:0] w_irdata, w_drdata;
        assign w_irdata = instr_resp_i[g].rdata;
        assign w_drdata = data_resp_i[g].rdata;
        assign w_beat_in[g] = '{instr_rvalid: instr_resp_i[g].rvalid,
                                instr_rdata:  w_irdata,
                                data_rvalid:  data_resp_i[g].rvalid,
                                data_rdata:   w_drdata,
                                intr:         intr_i[g],
                                debug:        debug_i[g]};

        lockstep_tap_delay #(
            .DEPTH (MAX_DELAY),
            .TAP_W (TAP_W)
        ) u_tap (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_clr   (w_arm),
            .i_shift (w_busy),
            .i_zero  (w_drain),
            .i_beat  (w_beat_in[g]),
            .i_tap   (w_tap_idx),
            .o_beat  (w_beat_dly[g])
        );
    end

    // Output muxing: passthrough by default, followers read the tap while busy.
    always_comb begin
        instr_resp_o = instr_resp_i;
        data_resp_o  = data_resp_i;
        intr_o       = intr_i;
        debug_o      = debug_i;
        if (w_busy) begin
            for (int h = 0; h < NHARTS; h++) begin
                if (LEAD_W'(h) != r_lead) begin
                    instr_resp_o[h].rvalid = w_beat_dly[h].instr_rvalid;
                    instr_resp_o[h].rdata  = w_beat_dly[h].instr_rdata;
                    data_resp_o[h].rvalid  = w_beat_dly[h].data_rvalid;
                    data_resp_o[h].rdata   = w_beat_dly[h].data_rdata;
                    intr_o[h]              = w_beat_dly[h].intr;
                    debug_o[h]             = w_beat_dly[h].debug;
                end
            end
        end
    end

    assign busy_o      = w_busy;
    assign state_o     = r_state;
    assign drain_err_o = r_err;

endmodule

// File: tb/tb_lockstep_resp_stagger.sv
// Directed bench for lockstep_resp_stagger (NHARTS=3, MAX_DELAY=4).
// Inputs change 1ns after posedge, outputs are checked on negedge.
module tb_lockstep_resp_stagger;
    import lockstep_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic [2:0]           delay;
    logic [1:0]           leader;
    obi_resp_t [2:0]      iri, iro, dri, dro;
    logic [2:0][31:0]     intri, intro;
    logic [2:0]           dbgi, dbgo;
    logic                 busy, derr;
    logic [1:0]           state;

    int n_tests = 0;
    int n_fail  = 0;

    lockstep_resp_stagger #(.NHARTS(3), .MAX_DELAY(4), .DW(32), .NIRQ(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .delay_i(delay), .leader_i(leader),
        .instr_resp_i(iri), .instr_resp_o(iro), .data_resp_i(dri), .data_resp_o(dro),
        .intr_i(intri), .intr_o(intro), .debug_i(dbgi), .debug_o(dbgo),
        .busy_o(busy), .state_o(state), .drain_err_o(derr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        en;
        logic [2:0]  dly;
        logic [1:0]  lead;
        logic [2:0]  irv;
        logic [31:0] ird;
        logic [2:0]  drv;
        logic [2:0]  dbg;
        logic [1:0]  e_st;
        logic        e_busy;
        logic        e_err;
        logic [8:0]  e_vld;   // {debug_o, data rvalid, instr rvalid}
        logic        chk_rd;
        logic [31:0] e_rd1;   // hart1 instr rdata when chk_rd
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic en, logic [2:0] dly, logic [1:0] lead, logic [2:0] irv,
                                logic [31:0] ird, logic [2:0] drv, logic [2:0] dbg,
                                logic [1:0] e_st, logic e_busy, logic e_err, logic [8:0] e_vld,
                                logic chk_rd, logic [31:0] e_rd1);
        vec_t v;
        v.en = en; v.dly = dly; v.lead = lead; v.irv = irv; v.ird = ird; v.drv = drv;
        v.dbg = dbg; v.e_st = e_st; v.e_busy = e_busy; v.e_err = e_err; v.e_vld = e_vld;
        v.chk_rd = chk_rd; v.e_rd1 = e_rd1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Instr rdata of hart h is ird+h; gnt patterns are arbitrary but distinct.
    task automatic drive(input logic en, input logic [2:0] dly, input logic [1:0] lead,
                         input logic [2:0] irv, input logic [31:0] ird,
                         input logic [2:0] drv, input logic [2:0] dbg);
        enable = en; delay = dly; leader = lead; dbgi = dbg;
        for (int h = 0; h < 3; h++) begin
            iri[h].gnt    = ~irv[h];
            iri[h].rvalid = irv[h];
            iri[h].rdata  = ird + 32'(h);
            dri[h].gnt    = drv[h];
            dri[h].rvalid = drv[h];
            dri[h].rdata  = ~ird;
            intri[h]      = '0;
        end
    endtask

    task automatic step(input logic en, input logic [2:0] dly, input logic [1:0] lead,
                        input logic [2:0] irv, input logic [31:0] ird,
                        input logic [2:0] drv, input logic [2:0] dbg);
        @(posedge clk); #1;
        drive(en, dly, lead, irv, ird, drv, dbg);
        @(negedge clk);
    endtask

    function automatic logic [8:0] get_vld();
        return {dbgo, dro[2].rvalid, dro[1].rvalid, dro[0].rvalid,
                iro[2].rvalid, iro[1].rvalid, iro[0].rvalid};
    endfunction

    function automatic logic [5:0] get_gnt();
        return {dro[2].gnt, dro[1].gnt, dro[0].gnt, iro[2].gnt, iro[1].gnt, iro[0].gnt};
    endfunction

    initial begin
        int dcyc;
        bit done;
        logic [1:0]  h4_st [8];
        logic        h4_v1 [8];
        logic [31:0] h4_rd [8];

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // D=2 L=0: basic stagger, gnt passthrough, drain of two beats
        tbl.push_back(mk(0,2,0,3'b010,32'h11,      0,     0,     0,0,0,9'b000_000_010,1,32'h12));
        tbl.push_back(mk(1,2,0,0,     0,           0,     0,     0,0,0,9'b0,          0,0));
        tbl.push_back(mk(1,2,0,3'b011,32'hDEADBEEE,0,     0,     1,1,0,9'b000_000_001,0,0));
        tbl.push_back(mk(1,2,0,0,     0,           0,     3'b100,1,1,0,9'b0,          0,0));
        tbl.push_back(mk(1,2,0,0,     0,           0,     0,     1,1,0,9'b000_000_010,1,32'hDEADBEEF));
        tbl.push_back(mk(1,2,0,0,     0,           3'b100,0,     1,1,0,9'b100_000_000,0,0));
        tbl.push_back(mk(0,2,0,0,     0,           0,     0,     1,1,0,9'b0,          0,0));
        tbl.push_back(mk(0,2,0,3'b001,0,           0,     0,     2,1,0,9'b000_100_001,0,0));
        tbl.push_back(mk(0,2,0,0,     0,           0,     0,     2,1,0,9'b0,          0,0));
        tbl.push_back(mk(0,2,0,3'b110,32'h20,      0,     0,     0,0,0,9'b000_000_110,1,32'h21));
        // D=1 L=1: follower data rvalid during DRAIN is dropped and flagged
        tbl.push_back(mk(1,1,1,0,     0,           0,     0,     0,0,0,9'b0,          0,0));
        tbl.push_back(mk(1,1,1,3'b001,32'h30,      0,     0,     1,1,0,9'b0,          0,0));
        tbl.push_back(mk(0,1,1,0,     32'h40,      0,     0,     1,1,0,9'b000_000_001,0,0));
        tbl.push_back(mk(0,1,1,0,     0,           3'b100,0,     2,1,0,9'b0,          0,0));
        tbl.push_back(mk(0,1,1,0,     0,           0,     0,     0,0,1,9'b0,          0,0));
        tbl.push_back(mk(0,1,1,0,     0,           0,     0,     0,0,1,9'b0,          0,0));
        // D=3, leader_i=3 (out of range -> 0), leader changes ignored; re-arm clears error
        tbl.push_back(mk(1,3,3,0,     0,           0,     0,     0,0,1,9'b0,          0,0));
        tbl.push_back(mk(1,3,1,3'b011,32'h50,      0,     0,     1,1,0,9'b000_000_001,0,0));
        tbl.push_back(mk(1,3,2,0,     0,           0,     0,     1,1,0,9'b0,          0,0));
        tbl.push_back(mk(1,3,2,0,     0,           0,     0,     1,1,0,9'b0,          0,0));
        tbl.push_back(mk(1,3,2,3'b100,0,           0,     0,     1,1,0,9'b000_000_010,1,32'h51));
        tbl.push_back(mk(0,3,2,0,     0,           0,     0,     1,1,0,9'b0,          0,0));

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_err",   32'(derr),  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].dly, tbl[i].lead, tbl[i].irv, tbl[i].ird, tbl[i].drv, tbl[i].dbg);
            chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].e_st));
            chk($sformatf("v%0d_busy", i),  32'(busy),  32'(tbl[i].e_busy));
            chk($sformatf("v%0d_err", i),   32'(derr),  32'(tbl[i].e_err));
            chk($sformatf("v%0d_vld", i),   32'(get_vld()), 32'(tbl[i].e_vld));
            chk($sformatf("v%0d_gnt", i),   32'(get_gnt()), 32'({tbl[i].drv, ~tbl[i].irv}));
            if (tbl[i].chk_rd) chk($sformatf("v%0d_rdata1", i), iro[1].rdata, tbl[i].e_rd1);
        end

        // D=3 drain: exactly three DRAIN cycles, bounded wait
        dcyc = 0; done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            if (state == 2'b10) dcyc++;
            else if (state == 2'b00) done = 1;
        end
        chk("drain3_done", 32'(done), 32'd1);
        chk("drain3_len",  32'(dcyc), 32'd3);

        // delay_i=7 saturates to 4; three beats in flight at disable all delivered in order
        h4_st = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        h4_v1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        h4_rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA1, 32'hB1, 32'hC1, 32'h0};
        step(1, 7, 0, 0, 0, 0, 0);
        chk("sat_arm_state", 32'(state), 32'd0);
        for (int c = 0; c < 8; c++) begin
            case (c)
                0:       step(1, 7, 0, 3'b010, 32'hA0, 0, 0);
                1:       step(1, 7, 0, 3'b010, 32'hB0, 0, 0);
                2:       step(0, 7, 0, 3'b010, 32'hC0, 0, 0);
                default: step(0, 7, 0, 0,      0,      0, 0);
            endcase
            chk($sformatf("sat_c%0d_state", c), 32'(state), 32'(h4_st[c]));
            chk($sformatf("sat_c%0d_rv1", c), 32'(iro[1].rvalid), 32'(h4_v1[c]));
            if (h4_v1[c]) chk($sformatf("sat_c%0d_rd1", c), iro[1].rdata, h4_rd[c]);
        end
        chk("sat_err", 32'(derr), 32'd0);

        // D=3 L=2: one-cycle interrupt on follower hart0, leader hart2 undelayed
        step(1, 3, 2, 0, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            drive(1, 3, 2, (j >= 6) ? 3'b010 : 3'b000, 32'h70, 0, 0);
            intri[0] = (j == 2) ? 32'h80 : 32'h0;
            intri[2] = 32'h100 + 32'(j);
            @(negedge clk);
            chk($sformatf("irq_j%0d_h0", j), intro[0], (j == 5) ? 32'h80 : 32'h0);
            chk($sformatf("irq_j%0d_h2", j), intro[2], 32'h100 + 32'(j));
        end

        // async reset mid-ACTIVE with hart1 beats in flight
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_busy",  32'(busy),  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            step(0, 3, 2, 0, 0, 0, 0);
            chk($sformatf("post_rst%0d_state", c), 32'(state), 32'd0);
            chk($sformatf("post_rst%0d_vld", c), 32'(get_vld()), 32'd0);
        end

        // D=0 request stays in BYPASS
        for (int c = 0; c < 3; c++) begin
            step(1, 0, 0, 3'b010, 32'h90, 0, 0);
            chk($sformatf("d0_%0d_state", c), 32'(state), 32'd0);
            chk($sformatf("d0_%0d_rv1", c), 32'(iro[1].rvalid), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
